// File: rtl/led_pwm_sequencer_if.sv
// Control and status bundle between the mode/brightness controls and the
// LED PWM sequencer. The master drives mode and peak duty and observes the
// LED drive, current duty, tick pulse and ramp direction.
interface led_pwm_sequencer_if;
  logic [1:0] mode;
  logic [7:0] duty_max;
  logic       led;
  logic [7:0] duty;
  logic       tick;
  logic       ramp_up;

  modport master (
    output mode,
    output duty_max,
    input  led,
    input  duty,
    input  tick,
    input  ramp_up
  );

  modport slave (
    input  mode,
    input  duty_max,
    output led,
    output duty,
    output tick,
    output ramp_up
  );
endinterface

// File: rtl/led_pwm_sequencer.sv
// LED PWM sequencer: tick prescaler, free-running 8-bit PWM counter and a
// duty-threshold sequencer for OFF / ON / BLINK / BREATHE modes.
module led_pwm_sequencer #(
  parameter int unsigned TICK_DIV    = 2500000,
  parameter int unsigned STEP        = 1,
  parameter int unsigned BLINK_TICKS = 50
) (
  input logic                  clk,
  input logic                  rst_n,
  led_pwm_sequencer_if.slave   bus
);

  localparam int unsigned   BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [29:0]   PRESC_LAST = 30'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [8:0]    STEP9      = 9'(STEP);

  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_ON       = 3'd1;
  localparam logic [2:0] S_BLINK_HI = 3'd2;
  localparam logic [2:0] S_BLINK_LO = 3'd3;
  localparam logic [2:0] S_UP       = 3'd4;
  localparam logic [2:0] S_DOWN     = 3'd5;

  logic [29:0]   r_presc;
  logic [7:0]    r_pwm_cnt;
  logic          r_led;
  logic [7:0]    r_duty;
  logic          r_ramp_up;
  logic [2:0]    r_state;
  logic [BW-1:0] r_blink_cnt;
  logic [1:0]    r_mode_q;

  logic          w_mode_chg;
  logic          w_tick;
  logic [8:0]    w_up_sum;
  logic [7:0]    w_up_next;
  logic          w_up_peak;
  logic          w_dn_zero;
  logic [7:0]    w_dn_next;
  logic          w_clamp;

  // A mode change suppresses the tick that would coincide with it.
  assign w_mode_chg = (bus.mode != r_mode_q);
  assign w_tick     = (r_presc == PRESC_LAST) && !w_mode_chg;

  // Ramp arithmetic: 9-bit sum so the up-ramp saturates at the peak instead
  // of wrapping; the down-ramp floors at zero.
  assign w_up_sum  = {1'b0, r_duty} + STEP9;
  assign w_up_next = (w_up_sum >= {1'b0, bus.duty_max}) ? bus.duty_max : w_up_sum[7:0];
  assign w_up_peak = (w_up_next == bus.duty_max) && (bus.duty_max != 8'd0);
  assign w_dn_zero = ({1'b0, r_duty} <= STEP9);
  assign w_dn_next = w_dn_zero ? 8'd0 : (r_duty - STEP9[7:0]);
  assign w_clamp   = (bus.duty_max < r_duty);

  assign bus.led     = r_led;
  assign bus.duty    = r_duty;
  assign bus.tick    = w_tick;
  assign bus.ramp_up = r_ramp_up;

  // Prescaler: counts 0..TICK_DIV-1, restarts from zero on a mode change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= 30'd0;
    end else if (w_mode_chg || (r_presc == PRESC_LAST)) begin
      r_presc <= 30'd0;
    end else begin
      r_presc <= r_presc + 30'd1;
    end
  end

  // Free-running PWM counter, wraps 255 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  // Registered LED drive: on while the PWM count is below the duty threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= 1'b0;
    end else begin
      r_led <= (r_pwm_cnt < r_duty);
    end
  end

  // Previous mode, used to detect a mode change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= 2'd0;
    end else begin
      r_mode_q <= bus.mode;
    end
  end

  // Sequencer FSM: owns state, duty threshold, ramp direction and blink count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_OFF;
      r_duty      <= 8'd0;
      r_ramp_up   <= 1'b0;
      r_blink_cnt <= '0;
    end else if (w_mode_chg) begin
      r_blink_cnt <= '0;
      case (bus.mode)
        2'd0: begin
          r_state   <= S_OFF;
          r_duty    <= 8'd0;
          r_ramp_up <= 1'b0;
        end
        2'd1: begin
          r_state   <= S_ON;
          r_duty    <= bus.duty_max;
          r_ramp_up <= 1'b0;
        end
        2'd2: begin
          r_state   <= S_BLINK_HI;
          r_duty    <= bus.duty_max;
          r_ramp_up <= 1'b0;
        end
        default: begin
          r_state   <= S_UP;
          r_duty    <= 8'd0;
          r_ramp_up <= 1'b1;
        end
      endcase
    end else begin
      case (r_state)
        S_OFF: begin
          r_duty    <= 8'd0;
          r_ramp_up <= 1'b0;
        end
        S_ON: begin
          r_duty    <= bus.duty_max;
          r_ramp_up <= 1'b0;
        end
        S_BLINK_HI: begin
          r_ramp_up <= 1'b0;
          if (w_tick && (r_blink_cnt == BLINK_LAST)) begin
            r_state     <= S_BLINK_LO;
            r_duty      <= 8'd0;
            r_blink_cnt <= '0;
          end else begin
            r_duty <= bus.duty_max;
            if (w_tick) begin
              r_blink_cnt <= r_blink_cnt + 1'b1;
            end
          end
        end
        S_BLINK_LO: begin
          r_ramp_up <= 1'b0;
          if (w_tick && (r_blink_cnt == BLINK_LAST)) begin
            r_state     <= S_BLINK_HI;
            r_duty      <= bus.duty_max;
            r_blink_cnt <= '0;
          end else begin
            r_duty <= 8'd0;
            if (w_tick) begin
              r_blink_cnt <= r_blink_cnt + 1'b1;
            end
          end
        end
        S_UP: begin
          if (w_clamp) begin
            r_state   <= S_DOWN;
            r_duty    <= bus.duty_max;
            r_ramp_up <= 1'b0;
          end else if (w_tick) begin
            r_duty <= w_up_next;
            if (w_up_peak) begin
              r_state   <= S_DOWN;
              r_ramp_up <= 1'b0;
            end
          end
        end
        S_DOWN: begin
          if (w_clamp) begin
            r_duty <= bus.duty_max;
          end else if (w_tick) begin
            r_duty <= w_dn_next;
            if (w_dn_zero) begin
              r_state   <= S_UP;
              r_ramp_up <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_OFF;
          r_duty    <= 8'd0;
          r_ramp_up <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Directed self-checking bench for led_pwm_sequencer with TICK_DIV=4,
// STEP=64, BLINK_TICKS=2.
module tb_led_pwm_sequencer;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;

  led_pwm_sequencer_if bus ();

  led_pwm_sequencer #(
    .TICK_DIV    (4),
    .STEP        (64),
    .BLINK_TICKS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] modeVal, input logic [7:0] dutyMaxVal);
    bus.mode     = modeVal;
    bus.duty_max = dutyMaxVal;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    int tickCount;
    int lastTick;
    int badGap;
    int badCycles;
    int ledHigh;
    logic [7:0] breatheDuty [9];
    logic       breatheRamp [9];

    nCompared   = 0;
    nMismatched = 0;
    breatheDuty = '{8'd64, 8'd128, 8'd192, 8'd200, 8'd136, 8'd72, 8'd8, 8'd0, 8'd64};
    breatheRamp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    applyStimulus(2'd0, 8'd0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_led", bus.led, 0);
    checkOutput("reset_duty", bus.duty, 0);
    checkOutput("reset_tick", bus.tick, 0);
    checkOutput("reset_ramp_up", bus.ramp_up, 0);
    #9 rst_n = 1'b1;

    // OFF: LED and duty stay low, tick every 4 clocks.
    tickCount = 0;
    lastTick  = -1;
    badGap    = 0;
    badCycles = 0;
    for (int i = 0; i < 1024; i++) begin
      stepClock();
      if (bus.led !== 1'b0 || bus.duty !== 8'd0) badCycles++;
      if (bus.tick === 1'b1) begin
        tickCount++;
        if (lastTick >= 0 && (i - lastTick) != 4) badGap++;
        lastTick = i;
      end
    end
    checkOutput("off_dark_cycles", badCycles, 0);
    checkOutput("off_tick_count", tickCount, 256);
    checkOutput("off_tick_gap", badGap, 0);

    // ON at 128: duty follows next clock, first tick 4 clocks after change.
    applyStimulus(2'd1, 8'd128);
    stepClock();
    checkOutput("on_duty", bus.duty, 128);
    stepClock();
    stepClock();
    checkOutput("on_tick_not_yet", bus.tick, 0);
    stepClock();
    checkOutput("on_first_tick", bus.tick, 1);
    ledHigh = 0;
    for (int i = 0; i < 256; i++) begin
      stepClock();
      if (bus.led === 1'b1) ledHigh++;
    end
    checkOutput("on_led_high_256", ledHigh, 128);

    // BREATHE to 200: ramp up, saturate, ramp down, restart.
    applyStimulus(2'd3, 8'd200);
    stepClock();
    checkOutput("breathe_entry_duty", bus.duty, 0);
    checkOutput("breathe_entry_ramp", bus.ramp_up, 1);
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) stepClock();
      checkOutput($sformatf("breathe_duty_%0d", k), bus.duty, breatheDuty[k]);
      checkOutput($sformatf("breathe_ramp_%0d", k), bus.ramp_up, breatheRamp[k]);
    end

    // BLINK at 255: 8 clocks high, 8 clocks low, then high again.
    applyStimulus(2'd2, 8'd255);
    for (int i = 1; i <= 16; i++) begin
      stepClock();
      checkOutput($sformatf("blink_duty_c%0d", i), bus.duty, (i <= 8) ? 255 : 0);
    end
    stepClock();
    checkOutput("blink_rehigh", bus.duty, 255);
    applyStimulus(2'd2, 8'd100);
    stepClock();
    checkOutput("blink_track_peak", bus.duty, 100);
    stepClock();
    stepClock();
    checkOutput("tick_before_collision", bus.tick, 1);

    // Mode change on a tick cycle drops the tick.
    applyStimulus(2'd3, 8'd200);
    #1;
    checkOutput("tick_dropped_on_change", bus.tick, 0);

    // BREATHE up to 192, then lower peak to 50: clamp and turn down.
    for (int i = 0; i < 13; i++) stepClock();
    checkOutput("clamp_pre_duty", bus.duty, 192);
    checkOutput("clamp_pre_ramp", bus.ramp_up, 1);
    applyStimulus(2'd3, 8'd50);
    stepClock();
    checkOutput("clamp_duty", bus.duty, 50);
    checkOutput("clamp_ramp", bus.ramp_up, 0);
    for (int i = 0; i < 3; i++) stepClock();
    checkOutput("clamp_floor_duty", bus.duty, 0);
    checkOutput("clamp_floor_ramp", bus.ramp_up, 1);

    // BREATHE with zero peak: duty pinned at 0, still ramping up.
    applyStimulus(2'd0, 8'd0);
    stepClock();
    checkOutput("off_again_duty", bus.duty, 0);
    checkOutput("off_again_ramp", bus.ramp_up, 0);
    applyStimulus(2'd3, 8'd0);
    stepClock();
    checkOutput("zero_peak_entry_ramp", bus.ramp_up, 1);
    badCycles = 0;
    for (int i = 0; i < 12; i++) begin
      stepClock();
      if (bus.duty !== 8'd0 || bus.ramp_up !== 1'b1) badCycles++;
    end
    checkOutput("zero_peak_hold", badCycles, 0);

    // Raise peak, climb one step, then reset asynchronously between edges.
    applyStimulus(2'd3, 8'd200);
    for (int i = 0; i < 4; i++) stepClock();
    checkOutput("pre_reset_duty", bus.duty, 64);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_led", bus.led, 0);
    checkOutput("async_reset_duty", bus.duty, 0);
    checkOutput("async_reset_tick", bus.tick, 0);
    checkOutput("async_reset_ramp", bus.ramp_up, 0);
    rst_n = 1'b1;
    stepClock();
    checkOutput("post_reset_entry_ramp", bus.ramp_up, 1);
    checkOutput("post_reset_entry_duty", bus.duty, 0);
    for (int i = 0; i < 4; i++) stepClock();
    checkOutput("post_reset_first_step", bus.duty, 64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
